// File: rtl/unit_sequencer.sv
// unit_sequencer: command engine for one processing unit.
// Takes a control packet from the system controller and runs a LOAD, STORE
// or COMPUTE sequence over an 8-entry local buffer. Shared memory is reached
// through a request/grant port with at most one request in flight.

package unit_sequencer_pkg;
   typedef struct packed {
      logic [5:0] encoded_control;
      logic [7:0] data_control;
   } control_packet_t;
endpackage

module unit_sequencer #(
   parameter logic [1:0] UNIT_ID    = 2'd0,
   parameter int         DATA_WIDTH = 32,
   parameter int         ADDR_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  unit_sequencer_pkg::control_packet_t unit_control,
   output logic                                unit_ready,
   output logic                                unit_done,
   output logic                                mem_req,
   output logic                                mem_we,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   input  logic                                mem_gnt,
   input  logic                                mem_rvalid,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   output logic [DATA_WIDTH-1:0]               result,
   output logic [15:0]                         busy_cycles
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_REQ,
      LOAD_WAIT,
      STORE_REQ,
      COMPUTE,
      DONE
   } state_t;

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_LOAD    = 2'b01;
   localparam logic [1:0] OP_STORE   = 2'b10;
   localparam logic [1:0] OP_COMPUTE = 2'b11;

   localparam logic [1:0] CT_SUM   = 2'b00;
   localparam logic [1:0] CT_MAX   = 2'b01;
   localparam logic [1:0] CT_RELU  = 2'b10;
   localparam logic [1:0] CT_CLEAR = 2'b11;

   state_t state, next_state;

   logic [1:0]            type_q;
   logic [3:0]            base_q;
   logic [2:0]            size_q;
   logic [2:0]            idx;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [DATA_WIDTH-1:0] data_buf [8];

   logic [1:0] pkt_id;
   logic [1:0] pkt_op;
   logic [1:0] pkt_type;
   logic [3:0] pkt_base;
   logic       pkt_valid;
   logic [2:0] pkt_size;
   logic       accept;
   logic       nop_seen;
   logic       last_elem;
   logic       busy;

   assign pkt_id    = unit_control.encoded_control[5:4];
   assign pkt_op    = unit_control.encoded_control[3:2];
   assign pkt_type  = unit_control.encoded_control[1:0];
   assign pkt_base  = unit_control.data_control[7:4];
   assign pkt_valid = unit_control.data_control[3];
   assign pkt_size  = unit_control.data_control[2:0];

   assign accept    = (pkt_id == UNIT_ID) && pkt_valid && (pkt_op != OP_NOP);
   assign nop_seen  = (pkt_id == UNIT_ID) && (pkt_op == OP_NOP);
   assign last_elem = (idx == size_q);
   assign busy      = (state == LOAD_REQ) || (state == LOAD_WAIT) ||
                      (state == STORE_REQ) || (state == COMPUTE);

   // State register; reset abandons any sequence in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection from the current command and memory handshake.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (pkt_op)
                  OP_LOAD:  next_state = LOAD_REQ;
                  OP_STORE: next_state = STORE_REQ;
                  default:  next_state = COMPUTE;
               endcase
            end
         end
         LOAD_REQ: begin
            if (mem_gnt) next_state = LOAD_WAIT;
         end
         LOAD_WAIT: begin
            if (mem_rvalid) next_state = last_elem ? DONE : LOAD_REQ;
         end
         STORE_REQ: begin
            if (mem_gnt && last_elem) next_state = DONE;
         end
         COMPUTE: begin
            if (last_elem) next_state = DONE;
         end
         DONE: begin
            if (nop_seen) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Memory port is a pure function of state so reset clears it at once.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == LOAD_REQ) begin
         mem_req  = 1'b1;
         mem_addr = ADDR_WIDTH'({base_q, idx});
      end else if (state == STORE_REQ) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = ADDR_WIDTH'({base_q, idx});
         mem_wdata = data_buf[idx];
      end
   end

   // Running reduction value for sum/max; seeded on the first element.
   always_comb begin
      acc_next = acc_q;
      if (type_q == CT_SUM) begin
         acc_next = ((idx == 3'd0) ? '0 : acc_q) + data_buf[idx];
      end else if (type_q == CT_MAX) begin
         if ((idx == 3'd0) || ($signed(data_buf[idx]) > $signed(acc_q))) begin
            acc_next = data_buf[idx];
         end
      end
   end

   // Command latch, index walk, buffer updates, result and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q      <= '0;
         base_q      <= '0;
         size_q      <= '0;
         idx         <= '0;
         acc_q       <= '0;
         result      <= '0;
         busy_cycles <= '0;
         unit_ready  <= 1'b1;
         unit_done   <= 1'b0;
         for (int i = 0; i < 8; i++) data_buf[i] <= '0;
      end else begin
         unit_ready <= (next_state == IDLE);
         unit_done  <= (next_state == DONE);
         if (busy && (busy_cycles != 16'hFFFF)) busy_cycles <= busy_cycles + 16'd1;
         case (state)
            IDLE: begin
               if (accept) begin
                  type_q <= pkt_type;
                  base_q <= pkt_base;
                  size_q <= pkt_size;
                  idx    <= '0;
               end
            end
            LOAD_WAIT: begin
               if (mem_rvalid) begin
                  data_buf[idx] <= mem_rdata;
                  if (!last_elem) idx <= idx + 3'd1;
               end
            end
            STORE_REQ: begin
               if (mem_gnt && !last_elem) idx <= idx + 3'd1;
            end
            COMPUTE: begin
               acc_q <= acc_next;
               if (type_q == CT_RELU && data_buf[idx][DATA_WIDTH-1]) data_buf[idx] <= '0;
               if (type_q == CT_CLEAR) data_buf[idx] <= '0;
               if (last_elem) begin
                  if (type_q == CT_SUM || type_q == CT_MAX) result <= acc_next;
                  else if (type_q == CT_CLEAR) result <= '0;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unit_sequencer.sv
// tb_unit_sequencer: directed bench for unit_sequencer with UNIT_ID=1.
// Drives packets and the memory handshake step by step from one initial
// block and checks outputs on the falling clock edge.

module tb_unit_sequencer;
   import unit_sequencer_pkg::*;

   logic            clk;
   logic            rst_n;
   control_packet_t unit_control;
   logic            unit_ready;
   logic            unit_done;
   logic            mem_req;
   logic            mem_we;
   logic [7:0]      mem_addr;
   logic [31:0]     mem_wdata;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [31:0]     mem_rdata;
   logic [31:0]     result;
   logic [15:0]     busy_cycles;

   int vectors;
   int miscompares;
   logic [31:0] load_data [8];
   logic [31:0] store_exp [8];
   logic [15:0] busy_before;

   unit_sequencer #(.UNIT_ID(2'd1), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .unit_control (unit_control),
      .unit_ready   (unit_ready),
      .unit_done    (unit_done),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .result       (result),
      .busy_cycles  (busy_cycles)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] id, input logic [1:0] op, input logic [1:0] ctype,
                                 input logic [3:0] base, input logic valid, input logic [2:0] size);
      unit_control.encoded_control = {id, op, ctype};
      unit_control.data_control    = {base, valid, size};
   endtask

   // Leave DONE: a held non-NOP packet must not restart, then NOP returns to IDLE.
   task automatic finish_cmd();
      check_output("done_flag", unit_done, 1);
      check_output("done_ready", unit_ready, 0);
      tick();
      check_output("done_hold", unit_done, 1);
      check_output("done_no_req", mem_req, 0);
      apply_stimulus(2'd1, 2'b00, 2'b00, 4'h0, 1'b1, 3'd0);
      tick();
      check_output("nop_ready", unit_ready, 1);
      check_output("nop_done", unit_done, 0);
   endtask

   task automatic do_load(input logic [3:0] base, input logic [2:0] size);
      apply_stimulus(2'd1, 2'b01, 2'b00, base, 1'b1, size);
      tick();
      check_output("load_ready_drop", unit_ready, 0);
      for (int i = 0; i <= int'(size); i++) begin
         check_output("load_req", mem_req, 1);
         check_output("load_we", mem_we, 0);
         check_output("load_addr", mem_addr, {1'b0, base, 3'(i)});
         mem_gnt = 1'b1;
         tick();
         mem_gnt = 1'b0;
         check_output("load_req_drop", mem_req, 0);
         tick();
         mem_rvalid = 1'b1;
         mem_rdata  = load_data[i];
         tick();
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
   endtask

   task automatic do_compute(input logic [1:0] ctype, input logic [2:0] size,
                             input logic [31:0] old_result, input logic [31:0] exp_result);
      busy_before = busy_cycles;
      apply_stimulus(2'd1, 2'b11, ctype, 4'h0, 1'b1, size);
      tick();
      for (int c = 0; c < int'(size); c++) tick();
      check_output("compute_not_done", unit_done, 0);
      check_output("compute_result_early", result, old_result);
      tick();
      check_output("compute_result", result, exp_result);
      check_output("compute_busy", busy_cycles, busy_before + 16'(int'(size) + 1));
   endtask

   task automatic do_store(input logic [3:0] base, input logic [2:0] size, input int stall);
      int writes;
      writes = 0;
      apply_stimulus(2'd1, 2'b10, 2'b00, base, 1'b1, size);
      tick();
      for (int i = 0; i <= int'(size); i++) begin
         if (i == 0) begin
            for (int s = 0; s < stall; s++) begin
               check_output("stall_req", mem_req, 1);
               check_output("stall_addr", mem_addr, {1'b0, base, 3'd0});
               check_output("stall_wdata", mem_wdata, store_exp[0]);
               tick();
            end
         end
         check_output("store_req", mem_req, 1);
         check_output("store_we", mem_we, 1);
         check_output("store_addr", mem_addr, {1'b0, base, 3'(i)});
         check_output("store_wdata", mem_wdata, store_exp[i]);
         writes += int'(mem_req);
         mem_gnt = 1'b1;
         tick();
         mem_gnt = 1'b0;
      end
      check_output("store_req_end", mem_req, 0);
      check_output("store_writes", writes, int'(size) + 1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      apply_stimulus(2'd0, 2'b00, 2'b00, 4'h0, 1'b0, 3'd0);
      tick();
      tick();
      check_output("rst_ready", unit_ready, 1);
      check_output("rst_done", unit_done, 0);
      check_output("rst_req", mem_req, 0);
      check_output("rst_addr", mem_addr, 0);
      check_output("rst_wdata", mem_wdata, 0);
      check_output("rst_result", result, 0);
      check_output("rst_busy", busy_cycles, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] filtering");
      apply_stimulus(2'd2, 2'b01, 2'b00, 4'h3, 1'b1, 3'd3);
      tick();
      check_output("filt_id_ready", unit_ready, 1);
      check_output("filt_id_req", mem_req, 0);
      apply_stimulus(2'd1, 2'b01, 2'b00, 4'h3, 1'b0, 3'd3);
      tick();
      check_output("filt_valid_ready", unit_ready, 1);
      check_output("filt_valid_req", mem_req, 0);
      apply_stimulus(2'd1, 2'b00, 2'b00, 4'h3, 1'b1, 3'd3);
      tick();
      check_output("filt_nop_ready", unit_ready, 1);
      check_output("filt_nop_req", mem_req, 0);

      $display("[TB] load 10,20,30,40 from 0x18");
      load_data[0] = 32'd10;
      load_data[1] = 32'd20;
      load_data[2] = 32'd30;
      load_data[3] = 32'd40;
      do_load(4'h3, 3'd3);
      check_output("load_busy", busy_cycles, 16'd12);
      finish_cmd();

      $display("[TB] compute sum");
      do_compute(2'b00, 3'd3, 32'd0, 32'd100);
      finish_cmd();

      $display("[TB] load -5,7,-2,3, then max and relu");
      load_data[0] = 32'hFFFF_FFFB;
      load_data[1] = 32'd7;
      load_data[2] = 32'hFFFF_FFFE;
      load_data[3] = 32'd3;
      do_load(4'h2, 3'd3);
      finish_cmd();
      do_compute(2'b01, 3'd3, 32'd100, 32'd7);
      finish_cmd();
      do_compute(2'b10, 3'd3, 32'd7, 32'd7);
      finish_cmd();

      $display("[TB] store with stalled grant");
      store_exp[0] = 32'd0;
      store_exp[1] = 32'd7;
      store_exp[2] = 32'd0;
      store_exp[3] = 32'd3;
      do_store(4'h0, 3'd3, 5);
      finish_cmd();

      $display("[TB] clear and single-word store");
      do_compute(2'b11, 3'd3, 32'd7, 32'd0);
      finish_cmd();
      store_exp[0] = 32'd0;
      do_store(4'hF, 3'd0, 0);
      finish_cmd();

      $display("[TB] reset during load");
      load_data[0] = 32'h1234_5678;
      apply_stimulus(2'd1, 2'b01, 2'b00, 4'h1, 1'b1, 3'd3);
      tick();
      check_output("mid_req", mem_req, 1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check_output("mid_wait_ready", unit_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("async_ready", unit_ready, 1);
      check_output("async_done", unit_done, 0);
      check_output("async_req", mem_req, 0);
      check_output("async_addr", mem_addr, 0);
      check_output("async_busy", busy_cycles, 0);
      apply_stimulus(2'd1, 2'b00, 2'b00, 4'h0, 1'b1, 3'd0);
      tick();
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      check_output("late_rvalid_ready", unit_ready, 1);
      check_output("late_rvalid_req", mem_req, 0);
      check_output("late_rvalid_done", unit_done, 0);
      store_exp[0] = 32'd0;
      do_store(4'h0, 3'd0, 0);
      finish_cmd();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
